mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single 32-bit/28-bit-address memory command port (DDR2 controller plus memory-mapped I/O at 0x800_0000 and above) between the data cache (port 0) and the I/O test/peripheral master (port 1). Round-robin grant, one outstanding command at a time, each command held until the downstream ready pulse. A watchdog aborts hung commands and reports a sticky timeout error. Sits between the requesters and the memory controller top level.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles a granted command may wait for mem_ready before abort (≥2).
- ABORT_RDATA, 32'hDEADBEEF: read data returned to the requester on timeout.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reqN_valid  in  1  (N=0,1) command valid; held high until reqN_ready.
- reqN_rw  in  1  1=write, 0=read; stable while valid.
- reqN_addr  in  28  command address; stable while valid.
- reqN_wdata  in  32  write data; stable while valid.
- reqN_ready  out  1  one-cycle completion pulse to requester N.
- reqN_rdata  out  32  read data, valid only in the reqN_ready cycle.
- mem_valid  out  1  command valid to memory side.
- mem_rw  out  1  registered copy of granted rw.
- mem_addr  out  28  registered copy of granted addr.
- mem_wdata  out  32  registered copy of granted wdata.
- mem_rdata  in  32  read data from memory side, valid with mem_ready.
- mem_ready  in  1  one-cycle completion pulse from memory side.
- grant  out  1  index of current/last granted requester.
- busy  out  1  high in BUSY state.
- timeout_err  out  1  sticky; set on any abort, cleared only by rst.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: if neither valid, stay. If exactly one valid, grant it. If both valid, grant the requester not equal to last_grant (round-robin). On grant: latch rw/addr/wdata into mem_* registers, set grant, last_grant, mem_valid←1, go BUSY.
- BUSY: mem_valid stays 1, mem_* stable. Watchdog counter increments each cycle.
  - mem_ready=1: reqG_ready=1 (combinational from mem_ready and state), reqG_rdata=mem_rdata; mem_valid←0; go GAP.
  - Counter reaches TIMEOUT_CYCLES with no mem_ready: mem_valid←0, timeout_err←1, reqG_ready pulse (registered, one cycle) with reqG_rdata=ABORT_RDATA; go GAP.
  - mem_ready and timeout on the same cycle: treat as normal completion, no error.
- GAP: one mandatory idle cycle so the requester can drop valid; no grant evaluated; go IDLE.
- Non-granted requester's ready always 0; its rdata drives 0.
- mem_ready outside BUSY is ignored (no ready pulse to any requester, no state change).
- Watchdog counter: clog2(TIMEOUT_CYCLES+1) bits, cleared on entry to BUSY, never wraps.

## Timing
- Reset values: mem_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0, reqN_ready=0, reqN_rdata=0, grant=0, busy=0, timeout_err=0, state=IDLE, last_grant=1 (port 0 wins the first tie).
- reqN_valid sampled high in IDLE at edge k → mem_valid/mem_* valid from after edge k (1-cycle latency).
- mem_ready in cycle j → reqG_ready in same cycle j; mem_valid low after edge j.
- Timeout: mem_valid first high in cycle c; abort ready pulse in cycle c+TIMEOUT_CYCLES.
- Minimum command-to-command spacing on mem side: BUSY end → GAP → IDLE → next mem_valid, i.e. 2 idle cycles of mem_valid.
- rst mid-BUSY: next cycle state=IDLE, mem_valid=0, no ready pulse issued; pending requester must reissue.

## Test plan
- Single read port 0, addr 28'h800_0004, mem_ready after 3 cycles with mem_rdata 32'h01000000 → mem_valid 3 cycles, req0_ready one pulse, req0_rdata=32'h01000000, req1_ready never.
- Both valid continuously, 4 commands each, mem_ready after 1 cycle → grant order 0,1,0,1,...; no requester granted twice in a row; mem_valid drops ≥2 cycles between commands.
- Port 1 write addr 28'h800_0005 wdata 32'h1 → mem_rw=1, mem_addr/mem_wdata match and stay stable through BUSY until mem_ready.
- TIMEOUT_CYCLES=8, port 0 read, mem_ready never → req0_ready at 8th cycle after mem_valid rise, req0_rdata=32'hDEADBEEF, timeout_err=1 and stays 1 across subsequent good commands.
- mem_ready on the exact timeout cycle → normal completion with mem_rdata, timeout_err stays 0; stray mem_ready in IDLE → no ready pulses.
- rst asserted during BUSY → following cycle mem_valid=0, busy=0, grant=0, no ready pulse; next request served normally, port 0 wins tie.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin memory command arbiter with watchdog abort
// Ports:
//   clk, rst                 : clock; synchronous active-high reset
//   reqN_valid/rw/addr/wdata : command from requester N (N=0 data cache, N=1 I/O master)
//   reqN_ready/rdata         : one-cycle completion pulse and read data to requester N
//   mem_valid/rw/addr/wdata  : registered command to the memory controller
//   mem_rdata/mem_ready      : read data and one-cycle completion pulse from the memory side
//   grant                    : index of the current/last granted requester
//   busy                     : a command is outstanding on the memory side
//   timeout_err              : sticky flag, set whenever the watchdog aborts a command
module mem_port_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ABORT_RDATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_rw,
  input  logic [27:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_rw,
  input  logic [27:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic [31:0] req1_rdata,
  output logic        mem_valid,
  output logic        mem_rw,
  output logic [27:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The abort decision is made in the last waiting cycle so that the
  // registered abort pulse lands exactly TIMEOUT_CYCLES after mem_valid rose.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_rw_q, mem_rw_d;
  logic [27:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          abort_q, abort_d;
  logic          timeout_err_q, timeout_err_d;
  logic          pick;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    mem_valid_d   = mem_valid_q;
    mem_rw_d      = mem_rw_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    wd_cnt_d      = wd_cnt_q;
    abort_d       = 1'b0;
    timeout_err_d = timeout_err_q;
    // Port 1 wins when it is the only one asking, or on a tie when port 0 went last.
    pick          = req1_valid & (~req0_valid | ~last_grant_q);

    case (state_q)
      S_IDLE: begin
        if (req0_valid | req1_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          mem_valid_d  = 1'b1;
          mem_rw_d     = pick ? req1_rw    : req0_rw;
          mem_addr_d   = pick ? req1_addr  : req0_addr;
          mem_wdata_d  = pick ? req1_wdata : req0_wdata;
          wd_cnt_d     = '0;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        // A completion arriving on the last waiting cycle still wins over the abort.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = S_GAP;
        end else if (wd_cnt_q == LAST_WAIT) begin
          mem_valid_d   = 1'b0;
          abort_d       = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = S_GAP;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      mem_valid_q   <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      wd_cnt_q      <= '0;
      abort_q       <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mem_valid_q   <= mem_valid_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      wd_cnt_q      <= wd_cnt_d;
      abort_q       <= abort_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Completion is either the live mem_ready in BUSY or the registered abort
  // pulse (which only ever occurs in GAP, so the two never overlap).
  logic        done_now;
  logic        resp_valid;
  logic [31:0] resp_data;

  assign done_now   = (state_q == S_BUSY) & mem_ready;
  assign resp_valid = ~rst & (done_now | abort_q);
  assign resp_data  = done_now ? mem_rdata : ABORT_RDATA;

  assign req0_ready  = resp_valid & ~grant_q;
  assign req1_ready  = resp_valid & grant_q;
  assign req0_rdata  = req0_ready ? resp_data : 32'd0;
  assign req1_rdata  = req1_ready ? resp_data : 32'd0;

  assign mem_valid   = mem_valid_q;
  assign mem_rw      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant       = grant_q;
  assign busy        = (state_q == S_BUSY);
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int          T     = 8;
  localparam logic [31:0] ABORT = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_rw = 1'b0;
  logic [27:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_rw = 1'b0;
  logic [27:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready;
  logic [31:0] req1_rdata;
  logic        mem_valid, mem_rw;
  logic [27:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        grant, busy, timeout_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(T), .ABORT_RDATA(ABORT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: who owns the port, how long it has waited,
  // how many enforced quiet cycles remain, and whether an abort is due.
  bit          m_active = 0, m_abort = 0, m_err = 0, m_grant = 0, m_last = 1;
  int          m_age = 0, m_quiet = 0, win = 0;
  logic        m_rw = 1'b0;
  logic [27:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  bit          resp, e_r0, e_r1;
  logic [31:0] e_data;

  bit          seen_ready[2];
  int          rdy_cnt[2];
  logic [31:0] last_rdata[2];
  int          rdy_cyc = 0, rise_cyc = 0, mv_cnt = 0, low_run = 0, min_gap = 1000;
  bit          prev_mv = 0, seen_high = 0;
  int          grant_log[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    resp   = !rst && ((m_active && mem_ready) || m_abort);
    e_data = (m_active && mem_ready) ? mem_rdata : ABORT;
    e_r0   = resp && (m_grant == 0);
    e_r1   = resp && (m_grant == 1);
    chk("mem_valid",   32'(mem_valid),   32'(m_active));
    chk("busy",        32'(busy),        32'(m_active));
    chk("mem_rw",      32'(mem_rw),      32'(m_rw));
    chk("mem_addr",    32'(mem_addr),    32'(m_addr));
    chk("mem_wdata",   mem_wdata,        m_wdata);
    chk("grant",       32'(grant),       32'(m_grant));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    chk("req0_ready",  32'(req0_ready),  32'(e_r0));
    chk("req1_ready",  32'(req1_ready),  32'(e_r1));
    chk("req0_rdata",  req0_rdata,       e_r0 ? e_data : 32'd0);
    chk("req1_rdata",  req1_rdata,       e_r1 ? e_data : 32'd0);

    if (req0_ready) begin rdy_cnt[0]++; last_rdata[0] = req0_rdata; rdy_cyc = cyc; end
    if (req1_ready) begin rdy_cnt[1]++; last_rdata[1] = req1_rdata; rdy_cyc = cyc; end
    if (mem_valid) begin
      mv_cnt++;
      if (!prev_mv) begin
        rise_cyc = cyc;
        grant_log.push_back(int'(grant));
        if (seen_high && low_run < min_gap) min_gap = low_run;
      end
      seen_high = 1;
      low_run   = 0;
    end else begin
      low_run++;
    end
    prev_mv = mem_valid;
    if (e_r0) seen_ready[0] = 1;
    if (e_r1) seen_ready[1] = 1;

    if (rst) begin
      m_active = 0; m_abort = 0; m_err = 0; m_grant = 0; m_last = 1;
      m_age = 0; m_quiet = 0; m_rw = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (m_abort) begin
      m_abort = 0;
    end else if (m_active) begin
      if (mem_ready) begin
        m_active = 0; m_quiet = 1;
      end else if (m_age == T - 1) begin
        m_active = 0; m_abort = 1; m_err = 1;
      end else begin
        m_age++;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (req0_valid || req1_valid) begin
      if (req0_valid && req1_valid) win = 1 - int'(m_last);
      else win = req1_valid ? 1 : 0;
      m_grant  = (win == 1);
      m_last   = (win == 1);
      m_active = 1;
      m_age    = 0;
      m_rw     = (win == 1) ? req1_rw    : req0_rw;
      m_addr   = (win == 1) ? req1_addr  : req0_addr;
      m_wdata  = (win == 1) ? req1_wdata : req0_wdata;
    end
  end

  // Stimulus: requesters and memory responder.
  int          done[2], issued[2], gap[2];
  bit          auto_on[2];
  int          limit = 0, gmax = 0, lat = 0;
  bit          stray = 0, fix_rdata = 0;
  logic [31:0] fixed_rdata = '0;

  task automatic issue(input int n, input logic rw, input logic [27:0] a, input logic [31:0] d);
    if (n == 0) begin req0_valid = 1'b1; req0_rw = rw; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = 1'b1; req1_rw = rw; req1_addr = a; req1_wdata = d; end
    issued[n]++;
  endtask

  task automatic tick();
    logic [27:0] a;
    @(posedge clk);
    #1;
    for (int n = 0; n < 2; n++) begin
      if (seen_ready[n]) begin
        seen_ready[n] = 0;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        done[n]++;
        gap[n] = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
      end else if (auto_on[n] && !((n == 0) ? req0_valid : req1_valid) &&
                   (limit == 0 || issued[n] < limit)) begin
        if (gap[n] > 0) gap[n]--;
        else begin
          a = 28'($urandom);
          issue(n, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
    end
    if (stray)        mem_ready = !m_active;
    else if (lat > 0) mem_ready = m_active && (m_age == lat - 1);
    else if (lat == 0) mem_ready = 1'b0;
    else              mem_ready = ($urandom_range(0, 3) == 0);
    mem_rdata = fix_rdata ? fixed_rdata : $urandom;
  endtask

  task automatic wait_done(input int n, input int target, input int budget);
    int k = 0;
    while (done[n] < target && k < budget) begin tick(); k++; end
    chk("wait_done", 32'(done[n] >= target), 32'd1);
  endtask

  initial begin
    int k, seen, r0, r1, d0;

    // Reset state
    tick(); tick();
    chk("rst_mem_valid",   32'(mem_valid),   32'd0);
    chk("rst_grant",       32'(grant),       32'd0);
    chk("rst_busy",        32'(busy),        32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);

    // Single read on port 0, three-cycle memory latency
    rst = 1'b0; lat = 3; fix_rdata = 1; fixed_rdata = 32'h01000000;
    mv_cnt = 0; rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    issue(0, 1'b0, 28'h8000004, 32'd0);
    wait_done(0, 1, 30);
    repeat (3) tick();
    chk("t1_mem_valid_cycles", mv_cnt, 3);
    chk("t1_req0_pulses",      rdy_cnt[0], 1);
    chk("t1_req1_pulses",      rdy_cnt[1], 0);
    chk("t1_req0_rdata",       last_rdata[0], 32'h01000000);

    // Both ports streaming, four commands each, one-cycle latency
    grant_log.delete(); seen_high = 0; min_gap = 1000;
    lat = 1; fix_rdata = 0; gmax = 0; limit = 4;
    done[0] = 0; done[1] = 0; issued[0] = 0; issued[1] = 0;
    auto_on[0] = 1; auto_on[1] = 1;
    k = 0;
    while ((done[0] < 4 || done[1] < 4) && k < 200) begin tick(); k++; end
    auto_on[0] = 0; auto_on[1] = 0; limit = 0;
    chk("t2_all_done", 32'(done[0] == 4 && done[1] == 4), 32'd1);
    chk("t2_grant_count", grant_log.size(), 8);
    // Port 0 went last in the previous test, so port 1 wins the first tie.
    for (int i = 0; i < grant_log.size(); i++)
      chk("t2_grant_order", grant_log[i], (i % 2 == 0) ? 32'd1 : 32'd0);
    chk("t2_min_gap", min_gap, 2);

    // Port 1 write held stable through BUSY
    lat = 4; d0 = done[1];
    issue(1, 1'b1, 28'h8000005, 32'h1);
    k = 0;
    while (!mem_valid && k < 5) begin tick(); k++; end
    seen = 0;
    while (mem_valid && seen < 20) begin
      chk("t3_mem_rw",    32'(mem_rw),   32'd1);
      chk("t3_mem_addr",  32'(mem_addr), 32'h8000005);
      chk("t3_mem_wdata", mem_wdata,     32'h1);
      seen++;
      tick();
    end
    chk("t3_busy_cycles", seen, 4);
    chk("t3_done", done[1], d0 + 1);
    tick();

    // Watchdog abort, then sticky error across a good command
    lat = 0; d0 = done[0];
    issue(0, 1'b0, 28'h0000123, 32'd0);
    wait_done(0, d0 + 1, 30);
    chk("t4_abort_latency", rdy_cyc - rise_cyc, T);
    chk("t4_abort_rdata",   last_rdata[0], ABORT);
    chk("t4_timeout_err",   32'(timeout_err), 32'd1);
    lat = 2;
    issue(1, 1'b0, 28'h0000055, 32'd0);
    wait_done(1, done[1] + 1, 20);
    repeat (2) tick();
    chk("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Completion on the exact timeout cycle, then stray mem_ready in IDLE
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk("t5_err_cleared", 32'(timeout_err), 32'd0);
    lat = T; fix_rdata = 1; fixed_rdata = 32'hCAFE0001;
    issue(0, 1'b0, 28'h0000200, 32'd0);
    wait_done(0, done[0] + 1, 30);
    chk("t5_ready_latency", rdy_cyc - rise_cyc, T - 1);
    chk("t5_rdata",         last_rdata[0], 32'hCAFE0001);
    repeat (2) tick();
    chk("t5_no_err", 32'(timeout_err), 32'd0);
    lat = 0; stray = 1; r0 = rdy_cnt[0]; r1 = rdy_cnt[1];
    repeat (6) tick();
    stray = 0;
    chk("t5_stray_req0", rdy_cnt[0], r0);
    chk("t5_stray_req1", rdy_cnt[1], r1);
    chk("t5_stray_busy", 32'(busy), 32'd0);

    // Reset during BUSY
    fix_rdata = 0; lat = 0;
    issue(1, 1'b1, 28'h0000777, 32'h9);
    k = 0;
    while (!mem_valid && k < 5) begin tick(); k++; end
    tick(); tick();
    r1 = rdy_cnt[1];
    rst = 1'b1;
    tick();
    chk("t6_mem_valid", 32'(mem_valid), 32'd0);
    chk("t6_busy",      32'(busy),      32'd0);
    chk("t6_grant",     32'(grant),     32'd0);
    chk("t6_no_pulse",  rdy_cnt[1],     r1);
    rst = 1'b0; grant_log.delete(); lat = 2;
    d0 = done[0]; r0 = done[1];
    issue(0, 1'b0, 28'h0000010, 32'd0);
    k = 0;
    while ((done[0] == d0 || done[1] == r0) && k < 40) begin tick(); k++; end
    chk("t6_both_served", 32'(done[0] > d0 && done[1] > r0), 32'd1);
    chk("t6_grant_count", 32'(grant_log.size() >= 2), 32'd1);
    if (grant_log.size() >= 2) begin
      chk("t6_first_grant",  grant_log[0], 32'd0);
      chk("t6_second_grant", grant_log[1], 32'd1);
    end

    // Randomized traffic: random gaps, latencies, strays, timeouts and resets
    lat = -1; gmax = 3; limit = 0; auto_on[0] = 1; auto_on[1] = 1;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; auto_on[0] = 0; auto_on[1] = 0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got still running, expected finished");
    $fatal(1);
  end

endmodule
